// File: rtl/icache_refill_ctrl.sv
// Fetch-side sequencer for a direct-mapped ICache: probes on accept,
// refills from memory on a miss, and forwards the instruction to decode.
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  input  logic              flush,
  input  logic              stall_from_dec,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] query_pc,
  input  logic              hit,
  input  logic [INST_W-1:0] query_inst,
  output logic              ena_to_icache,
  output logic [ADDR_W-1:0] addr_to_icache,
  output logic [INST_W-1:0] inst_to_icache,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_DRAIN,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              ena_q, ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [INST_W-1:0] wr_data_q, wr_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic accept;

  assign fetch_ready = (state_q == S_IDLE) && !flush && rdy;
  assign accept      = fetch_valid && fetch_ready;
  assign query_pc    = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      ena_q        <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      ena_q        <= ena_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = hit ? S_OUT : S_MISS;
      end
      S_MISS: begin
        if (mem_done) state_d = flush ? S_IDLE : S_OUT;
        else if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_done) state_d = S_IDLE;
      end
      S_OUT: begin
        if (flush || !stall_from_dec) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    ena_d        = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          inst_pc_d = fetch_pc;
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_out_d   = query_inst;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      S_MISS, S_DRAIN: begin
        // The read is never aborted: a flushed refill still fills the cache.
        if (mem_done) begin
          mem_req_d = 1'b0;
          ena_d     = 1'b1;
          wr_addr_d = inst_pc_q;
          wr_data_d = mem_data;
          if (state_q == S_MISS && !flush) begin
            inst_valid_d = 1'b1;
            inst_out_d   = mem_data;
          end
        end
      end
      S_OUT: begin
        if (flush || !stall_from_dec) inst_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign inst_valid     = inst_valid_q;
  assign inst_out       = inst_out_q;
  assign inst_pc        = inst_pc_q;
  assign ena_to_icache  = ena_q;
  assign addr_to_icache = wr_addr_q;
  assign inst_to_icache = wr_data_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule
